fp32_pack_round: RTL
====================

// Module: fp32_pack_round
// PURPOSE
//  Inverse of the FPU classifier: assembles an IEEE-754 single from unpacked sign/exponent/mantissa
//  or from a one-hot fclass code, normalising and rounding (RNE) over multiple cycles.
//  Sits at the write-back end of the FPU datapath (after add/mul cores). Valid/ready on both sides.
//  One operation in flight.
// PARAMETERS
//  EXP_W     10            signed biased-exponent input width (two's complement)
//  QNAN_VAL  32'h7FC0_0000 canonical quiet-NaN output pattern
//  SNAN_VAL  32'h7FA0_0000 signalling-NaN output pattern
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      reset, asynchronous, active-low
//  in_valid   in   1      input operand valid
//  in_ready   out  1      block can accept (high only in IDLE)
//  in_sign    in   1      sign
//  in_exp     in   EXP_W  signed biased exponent (127 = 2^0)
//  in_mant    in   27     [26] carry, [25] hidden, [24:2] fraction, [1] guard, [0] sticky
//  in_class   in   10     one-hot fclass code (0 -Inf,3 -0,4 +0,7 +Inf,8 sNaN,9 qNaN); 0 = numeric
//  out_valid  out  1      result valid, held until out_ready
//  out_ready  in   1      downstream accepts result
//  out_data   out  32     packed IEEE single
//  out_flags  out  3      {overflow, underflow, inexact}, aligned with out_data
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, in_ready=1, out_valid=0, out_data=0, out_flags=0.
//  rst_n low mid-operation aborts the op; no output is produced.
//  FSM IDLE->NORM->ROUND->DONE->IDLE; special path IDLE->DONE->IDLE.
//  IDLE: on in_valid&in_ready, register all inputs.
//   If in_class has any of bits {0,3,4,7,8,9} set, go to DONE. Priority: highest set bit wins.
//   Results: 9->QNAN_VAL, 8->SNAN_VAL, 7->32'h7F80_0000, 4->0, 3->32'h8000_0000, 0->32'hFF80_0000.
//   NaN outputs ignore in_sign; flags=0. Bits 1,2,5,6 alone go to the numeric path.
//  NORM: one step per cycle, in priority order:
//   a) mant==0 -> signed zero result, flags=0, go DONE.
//   b) mant[26]=1 -> shift right 1 (bit0 |= shifted-out bit), exp+1.
//   c) exp<1 -> shift right 1 (sticky OR), exp+1 (denormalise toward exp=1).
//   d) mant[25]=0 and exp>1 -> shift left 1, exp-1.
//   e) otherwise go ROUND.
//   Left-shift count is bounded by 25. Right-shift: once mant==0 except sticky, exp jumps to 1.
//  ROUND: inc = guard & (sticky | mant[2]); mant[26:2] += inc.
//   Carry into bit26 -> shift right 1, exp+1.
//   inexact = guard|sticky (pre-round).
//   exp>=255 -> +/-Inf, overflow=1, inexact=1.
//   Field exponent = mant[25] ? exp[7:0] : 0; underflow = (field exp==0) & inexact.
//   Go DONE.
//  DONE: out_valid=1, out_data/out_flags stable. On out_ready go IDLE (in_ready rises next cycle).
//  Latency: normalised numeric input accepted cycle N -> out_valid at N+3.
//   Each extra shift adds 1 cycle. Special path: out_valid at N+1.
//  in_ready=0 outside IDLE; in_valid then is ignored. Inputs need only be stable at acceptance.
// TESTING
//  exp=127, mant=1<<25, class=0 -> 32'h3F80_0000, flags=0, out_valid 3 cycles after accept.
//  exp=254, mant=1<<26 -> 32'h7F80_0000, flags=3'b101.
//  exp=0, mant=1<<25 -> 32'h0040_0000 (2^-127 subnormal), flags=0, 1 extra cycle.
//  exp=127, mant[25:1]=all ones, sticky=0 -> 32'h4000_0000, inexact=1.
//  in_class=10'h200 -> 32'h7FC0_0000 at N+1; in_class=10'h081 -> 32'h7F80_0000.
//  Hold out_ready=0 10 cycles -> out_data stable, in_ready=0.
//  Pulse rst_n low in NORM -> out_valid stays 0, in_ready=1.

Source files
------------

// File: rtl/fp32_pack_round.sv
// rtl/fp32_pack_round.sv - IEEE-754 single packer with multi-cycle normalise and RNE rounding
//
// Purpose: builds a packed IEEE-754 single either from unpacked sign/exponent/mantissa
// (normalising one shift per cycle, then rounding to nearest-even) or directly from a
// one-hot fclass code for the special values. One operation in flight.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake; in_ready is high only while idle
//   in_sign, in_exp       sign and two's-complement biased exponent (127 = 2^0)
//   in_mant               [26] carry, [25] hidden, [24:2] fraction, [1] guard, [0] sticky
//   in_class              one-hot fclass code; zero (or only bits 1,2,5,6) selects numeric path
//   out_valid / out_ready result handshake; result held until accepted
//   out_data, out_flags   packed single and {overflow, underflow, inexact}
module fp32_pack_round #(
  parameter int          EXP_W    = 10,
  parameter logic [31:0] QNAN_VAL = 32'h7FC0_0000,
  parameter logic [31:0] SNAN_VAL = 32'h7FA0_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [26:0]      in_mant,
  input  logic [9:0]       in_class,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [2:0]       out_flags
);

  // Two extra exponent bits give headroom for the carry increment and denormalising shifts.
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);
  localparam logic signed [EW-1:0] EXP_INF = EW'(255);
  localparam logic [9:0] SPECIAL_MASK = 10'b11_1001_1001;
  localparam logic [4:0] LSH_MAX = 5'd25;

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 sign_q, sign_d;
  logic signed [EW-1:0] exp_q, exp_d;
  logic [26:0]          mant_q, mant_d;
  logic [4:0]           lsh_cnt_q, lsh_cnt_d;
  logic [31:0]          out_data_q, out_data_d;
  logic [2:0]           out_flags_q, out_flags_d;

  logic [9:0]           special;
  logic [26:0]          mant_rsh;
  logic [26:0]          mant_lsh;
  logic signed [EW-1:0] exp_inc;
  logic signed [EW-1:0] exp_dec;

  logic                 guard;
  logic                 sticky;
  logic                 rnd_inc;
  logic                 inexact;
  logic [24:0]          rnd;
  logic                 hidden;
  logic [22:0]          frac;
  logic signed [EW-1:0] exp_rnd;
  logic [7:0]           field_exp;

  assign special  = in_class & SPECIAL_MASK;
  // Right shift folds the dropped bit into sticky so RNE still sees everything below guard.
  assign mant_rsh = {1'b0, mant_q[26:2], mant_q[1] | mant_q[0]};
  assign mant_lsh = {mant_q[25:0], 1'b0};
  assign exp_inc  = exp_q + EXP_ONE;
  assign exp_dec  = exp_q - EXP_ONE;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;

  // Rounding datapath; only consumed in ROUND, where mant_q[26] is already clear.
  always_comb begin
    guard     = mant_q[1];
    sticky    = mant_q[0];
    rnd_inc   = guard & (sticky | mant_q[2]);
    inexact   = guard | sticky;
    rnd       = mant_q[26:2] + {24'd0, rnd_inc};
    hidden    = rnd[23];
    frac      = rnd[22:0];
    exp_rnd   = exp_q;
    if (rnd[24]) begin
      // Rounding carried past the hidden bit: renormalise by one.
      hidden  = rnd[24];
      frac    = rnd[23:1];
      exp_rnd = exp_inc;
    end
    field_exp = hidden ? exp_rnd[7:0] : 8'd0;
  end

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    lsh_cnt_d   = lsh_cnt_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d    = in_sign;
          exp_d     = {{2{in_exp[EXP_W-1]}}, in_exp};
          mant_d    = in_mant;
          lsh_cnt_d = 5'd0;
          if (special != 10'd0) begin
            out_flags_d = 3'b000;
            state_d     = S_DONE;
            if (special[9])      out_data_d = QNAN_VAL;
            else if (special[8]) out_data_d = SNAN_VAL;
            else if (special[7]) out_data_d = 32'h7F80_0000;
            else if (special[4]) out_data_d = 32'h0000_0000;
            else if (special[3]) out_data_d = 32'h8000_0000;
            else                 out_data_d = 32'hFF80_0000;
          end else begin
            state_d = S_NORM;
          end
        end
      end

      S_NORM: begin
        if (mant_q == 27'd0) begin
          out_data_d  = {sign_q, 31'd0};
          out_flags_d = 3'b000;
          state_d     = S_DONE;
        end else if (mant_q[26]) begin
          mant_d = mant_rsh;
          exp_d  = exp_inc;
        end else if (exp_q < EXP_ONE) begin
          // Once only sticky remains, further shifts cannot change the mantissa.
          if (mant_q[26:1] == 26'd0) begin
            exp_d = EXP_ONE;
          end else begin
            mant_d = mant_rsh;
            exp_d  = exp_inc;
          end
        end else if (!mant_q[25] && (exp_q > EXP_ONE) && (lsh_cnt_q < LSH_MAX)) begin
          mant_d    = mant_lsh;
          exp_d     = exp_dec;
          lsh_cnt_d = lsh_cnt_q + 5'd1;
        end else begin
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        state_d = S_DONE;
        if (exp_rnd >= EXP_INF) begin
          out_data_d  = {sign_q, 8'hFF, 23'd0};
          out_flags_d = 3'b101;
        end else begin
          out_data_d  = {sign_q, field_exp, frac};
          out_flags_d = {1'b0, (field_exp == 8'd0) & inexact, inexact};
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= 27'd0;
      lsh_cnt_q   <= 5'd0;
      out_data_q  <= 32'd0;
      out_flags_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      lsh_cnt_q   <= lsh_cnt_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
    end
  end

endmodule
